// File: rtl/operand_dispatcher_pkg.sv
// Shared types and default widths for the operand dispatcher and its FIFO.
// The optional watchdog is enabled with OPERAND_DISPATCHER_TIMEOUT_EN.
package operand_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Default widths match the arithmetic core's operand and result buses.
  localparam int DEF_W    = 16;
  localparam int DEF_KW   = 8;
  localparam int DEF_TAGW = 8;

endpackage

// File: rtl/operand_dispatcher_if.sv
// Producer-side operand port and consumer-side result port of the dispatcher.
// Both ports use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both 1; the sender keeps valid and data stable until then.
interface operand_dispatcher_if #(
  parameter int W    = 16,
  parameter int KW   = 8,
  parameter int TAGW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic [W-1:0]    in_c;
  logic [KW-1:0]   in_k;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_resultado;
  logic [TAGW-1:0] out_tag;
  logic            out_timeout;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_k, out_ready,
    output in_ready, out_valid, out_resultado, out_tag, out_timeout
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_k, out_ready,
    input  in_ready, out_valid, out_resultado, out_tag, out_timeout
  );
endinterface

// File: rtl/operand_dispatcher_fifo.sv
// dispatch_fifo: power-of-two synchronous FIFO with occupancy count.
// Storage is not reset; only pointers and count are.
module dispatch_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when a pop frees the slot in the same cycle.
  always_comb begin
    push_ok  = push && (!full || pop);
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/operand_dispatcher.sv
// Buffers operand sets, runs the core's inicio/pronto handshake and offers tagged
// results downstream. OPERAND_DISPATCHER_TIMEOUT_EN adds a BUSY watchdog.
module operand_dispatcher
  import operand_dispatcher_pkg::*;
#(
  parameter int W              = DEF_W,
  parameter int KW             = DEF_KW,
  parameter int DEPTH          = 4,
  parameter int TAGW           = DEF_TAGW,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  operand_dispatcher_if.slave    bus,
  output logic [W-1:0]           core_a,
  output logic [W-1:0]           core_b,
  output logic [W-1:0]           core_c,
  output logic [KW-1:0]          core_k,
  output logic                   inicio,
  input  logic                   pronto,
  input  logic [W-1:0]           resultado,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output state_t                 dbg_state
);
  localparam int OPW = 3*W + KW;

  state_t          state_q, state_d;
  logic [W-1:0]    core_a_q, core_a_d, core_b_q, core_b_d, core_c_q, core_c_d;
  logic [KW-1:0]   core_k_q, core_k_d;
  logic            inicio_q, inicio_d;
  logic            armed_q, armed_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_res_q, out_res_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;
  logic [TAGW-1:0] tag_q, tag_d;

  logic            fifo_pop, fifo_full, fifo_empty;
  logic [OPW-1:0]  fifo_rdata;
  logic [W-1:0]    head_a, head_b, head_c;
  logic [KW-1:0]   head_k;

`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic            out_timeout_q, out_timeout_d;
`endif

  dispatch_fifo #(.DW(OPW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (bus.in_valid && bus.in_ready),
    .wdata ({bus.in_a, bus.in_b, bus.in_c, bus.in_k}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_a, head_b, head_c, head_k} = fifo_rdata;

  always_comb begin
    state_d     = state_q;
    core_a_d    = core_a_q;
    core_b_d    = core_b_q;
    core_c_d    = core_c_q;
    core_k_d    = core_k_q;
    inicio_d    = inicio_q;
    armed_d     = armed_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_tag_d   = out_tag_q;
    tag_d       = tag_q;
    fifo_pop    = 1'b0;
`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    out_timeout_d = out_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          core_a_d = head_a;
          core_b_d = head_b;
          core_c_d = head_c;
          core_k_d = head_k;
          fifo_pop = 1'b1;
          inicio_d = 1'b1;
          armed_d  = 1'b0;
          state_d  = ST_BUSY;
`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_BUSY: begin
        // pronto only counts once it has been seen low during this job.
        if (!pronto) armed_d = 1'b1;
        if (armed_q && pronto) begin
          out_res_d   = resultado;
          out_tag_d   = tag_q;
          tag_d       = tag_q + TAGW'(1);
          inicio_d    = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          out_res_d     = '0;
          out_tag_d     = tag_q;
          tag_d         = tag_q + TAGW'(1);
          out_timeout_d = 1'b1;
          inicio_d      = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
`endif
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_GAP;
`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
          out_timeout_d = 1'b0;
`endif
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      core_a_q    <= '0;
      core_b_q    <= '0;
      core_c_q    <= '0;
      core_k_q    <= '0;
      inicio_q    <= 1'b0;
      armed_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      core_c_q    <= core_c_d;
      core_k_q    <= core_k_d;
      inicio_q    <= inicio_d;
      armed_q     <= armed_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_tag_q   <= out_tag_d;
      tag_q       <= tag_d;
    end
  end

`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q     <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      out_timeout_q <= out_timeout_d;
    end
  end
  assign bus.out_timeout = out_timeout_q;
`else
  assign bus.out_timeout = 1'b0;
`endif

  assign bus.in_ready      = !fifo_full;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_resultado = out_res_q;
  assign bus.out_tag       = out_tag_q;
  assign core_a            = core_a_q;
  assign core_b            = core_b_q;
  assign core_c            = core_c_q;
  assign core_k            = core_k_q;
  assign inicio            = inicio_q;
  assign busy              = (state_q != ST_IDLE);
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_operand_dispatcher.sv
// Bench for operand_dispatcher: stub core, directed scenarios, random traffic and
// a scoreboard fed at operand acceptance and drained at result transfer.
module tb_operand_dispatcher;
  import operand_dispatcher_pkg::*;

  localparam int W     = 16;
  localparam int KW    = 8;
  localparam int TAGW  = 8;
  localparam int DEPTH = 4;
`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif
  localparam int EW = 1 + TAGW + W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [W-1:0]           core_a, core_b, core_c;
  logic [KW-1:0]          core_k;
  logic                   inicio;
  logic                   pronto;
  logic [W-1:0]           resultado;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  state_t                 dbg_state;

  operand_dispatcher_if #(.W(W), .KW(KW), .TAGW(TAGW)) bus ();

  operand_dispatcher #(
    .W(W), .KW(KW), .DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_c     (core_c),
    .core_k     (core_k),
    .inicio     (inicio),
    .pronto     (pronto),
    .resultado  (resultado),
    .busy       (busy),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int model_tag = 0;
  logic stale_mode = 1'b0;
  logic hang_mode  = 1'b0;

  // ---------------- stub core ----------------
  // pronto rises 3 cycles after inicio rises; result latched at that moment.
  logic [2:0] stub_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stub_cnt  <= '0;
      pronto    <= 1'b0;
      resultado <= '0;
    end else if (inicio) begin
      if (stub_cnt != 3'd7) stub_cnt <= stub_cnt + 3'd1;
      if (stub_cnt == 3'd0) pronto <= 1'b0;
      if (stub_cnt == 3'd2 && !hang_mode) begin
        pronto    <= 1'b1;
        resultado <= core_a + core_b + core_c + W'(core_k);
      end
    end else begin
      stub_cnt <= '0;
      if (!stale_mode) pronto <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [W-1:0] model_sum(input int a, input int b, input int c, input int k);
    return W'(a + b + c + k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    model_tag = 0;
  endtask

  // ---------------- driver ----------------
  task automatic push(input int a, input int b, input int c, input int k);
    int n;
    bus.in_valid = 1'b1;
    bus.in_a = W'(a);
    bus.in_b = W'(b);
    bus.in_c = W'(c);
    bus.in_k = KW'(k);
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) expire("push_ready");
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_rand();
    push($urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF),
         $urandom_range(0, 16'hFFFF), $urandom_range(0, 8'hFF));
  endtask

  task automatic wait_out_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) expire(name);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || fifo_count != 0 || exp_q.size() != 0) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) expire(name);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (bus.in_valid && bus.in_ready) begin
        if (hang_mode)
          exp_q.push_back({1'b1, TAGW'(model_tag), W'(0)});
        else
          exp_q.push_back({1'b0, TAGW'(model_tag),
                           model_sum(int'(bus.in_a), int'(bus.in_b), int'(bus.in_c), int'(bus.in_k))});
        model_tag = (model_tag + 1) % (1 << TAGW);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          expire("unexpected_result");
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("sb_resultado", 32'(bus.out_resultado), 32'(e[W-1:0]));
          check("sb_tag",       32'(bus.out_tag),       32'(e[W+TAGW-1:W]));
          check("sb_timeout",   32'(bus.out_timeout),   32'(e[EW-1]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0]    held_res;
  logic [TAGW-1:0] held_tag;
  bit              rand_done;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_c      = '0;
    bus.in_k      = '0;
    bus.out_ready = 1'b0;
    do_reset();
    repeat (3) tick();

    check("rst_in_ready",   32'(bus.in_ready), 1);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_inicio",     32'(inicio), 0);
    check("rst_out_valid",  32'(bus.out_valid), 0);
    check("rst_out_timeout",32'(bus.out_timeout), 0);
    check("rst_busy",       32'(busy), 0);
    check("rst_core",       32'({core_a, core_b, core_c, core_k}), 0);
    check("rst_out_res",    32'(bus.out_resultado), 0);
    check("rst_out_tag",    32'(bus.out_tag), 0);
    rst = 1'b1;
    tick();

    // single job then backpressure
    push(3, 4, 6, 8);
    check("no_bypass_inicio", 32'(inicio), 0);
    tick();
    check("single_inicio", 32'(inicio), 1);
    check("single_core_a", 32'(core_a), 3);
    check("single_core_b", 32'(core_b), 4);
    check("single_core_c", 32'(core_c), 6);
    check("single_core_k", 32'(core_k), 8);
    wait_out_valid("single_out_valid");
    check("single_res", 32'(bus.out_resultado), 21);
    check("single_tag", 32'(bus.out_tag), 0);
    push(1, 2, 3, 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid",  32'(bus.out_valid), 1);
      check("bp_res",    32'(bus.out_resultado), 21);
      check("bp_tag",    32'(bus.out_tag), 0);
      check("bp_inicio", 32'(inicio), 0);
      check("bp_count",  32'(fifo_count), 1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("gap_out_valid", 32'(bus.out_valid), 0);
    check("gap_state",     32'(dbg_state), 32'(ST_GAP));
    check("gap_inicio",    32'(inicio), 0);
    tick();
    check("idle_inicio",   32'(inicio), 0);
    tick();
    check("restart_inicio", 32'(inicio), 1);
    check("restart_core_a", 32'(core_a), 1);
    wait_idle("drain_single");

    // fill: five back-to-back pushes
    for (int i = 0; i < 5; i++) push_rand();
    check("fill_count",    32'(fifo_count), DEPTH);
    check("fill_in_ready", 32'(bus.in_ready), 0);
    wait_idle("drain_fill");

    // stale pronto carried over into the next job
    stale_mode = 1'b1;
    push_rand();
    push_rand();
    push_rand();
    wait_idle("drain_stale");
    stale_mode = 1'b0;
    tick();

    // random traffic with random consumer stalls, long enough to wrap the tag
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 270; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push_rand();
        end
        rand_done = 1'b1;
      end
      begin
        int n = 0;
        while (!(rand_done && exp_q.size() == 0) && n < 20000) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          tick();
          n++;
        end
        if (n >= 20000) expire("rand_drain");
      end
    join
    bus.out_ready = 1'b1;
    wait_idle("drain_rand");

    // reset in the middle of a job, with a second job queued
    push_rand();
    push_rand();
    begin
      int n = 0;
      while (!inicio && n < 50) begin tick(); n++; end
      if (n >= 50) expire("mid_inicio");
    end
    tick();
    tick();
    #2;
    do_reset();
    #1;
    check("mid_inicio_rst", 32'(inicio), 0);
    check("mid_busy",       32'(busy), 0);
    check("mid_out_valid",  32'(bus.out_valid), 0);
    check("mid_count",      32'(fifo_count), 0);
    check("mid_in_ready",   32'(bus.in_ready), 1);
    check("mid_core",       32'({core_a, core_b, core_c, core_k}), 0);
    tick();
    rst = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    push(100, 200, 300, 40);
    wait_out_valid("post_rst_valid");
    check("post_rst_tag", 32'(bus.out_tag), 0);
    check("post_rst_res", 32'(bus.out_resultado), 640);
    bus.out_ready = 1'b1;
    wait_idle("drain_post_rst");

`ifdef OPERAND_DISPATCHER_TIMEOUT_EN
    hang_mode = 1'b1;
    bus.out_ready = 1'b0;
    push_rand();
    begin
      int n = 0;
      while (!inicio && n < 50) begin tick(); n++; end
      if (n >= 50) expire("tmo_inicio");
      n = 0;
      while (!bus.out_valid && n < 100) begin tick(); n++; end
      check("tmo_busy_cycles", 32'(n), TMO);
    end
    check("tmo_flag", 32'(bus.out_timeout), 1);
    check("tmo_res",  32'(bus.out_resultado), 0);
    check("tmo_inicio_low", 32'(inicio), 0);
    bus.out_ready = 1'b1;
    tick();
    check("tmo_flag_clear", 32'(bus.out_timeout), 0);
    hang_mode = 1'b0;
    wait_idle("drain_tmo");
`endif

    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(80000 * 10);
    n_cmp++;
    n_err++;
    $display("FAIL global_watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
